// File: rtl/axis_testpattern_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : axis_testpattern_sequencer
// Description : Frames a free-running AXI-Stream pattern into counted packets
//               with tlast, programmable inter-packet gap and run control.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_testpattern_sequencer #(
    parameter int TDATA_WIDTH = 32,
    parameter int LEN_WIDTH   = 16,
    parameter int CNT_WIDTH   = 16,
    parameter int GAP_WIDTH   = 8
) (
    input  logic                   m_axis_aclk,
    input  logic                   m_axis_aresetn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [LEN_WIDTH-1:0]   cfg_pkt_len,
    input  logic [CNT_WIDTH-1:0]   cfg_pkt_count,
    input  logic [GAP_WIDTH-1:0]   cfg_gap,
    output logic                   gen_enable,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   pkt_sent
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [LEN_WIDTH-1:0] c_len_one = LEN_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);
    localparam logic [GAP_WIDTH-1:0] c_gap_one = GAP_WIDTH'(1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LEN_WIDTH-1:0]   r_len_m1;
    logic [CNT_WIDTH-1:0]   r_count;
    logic [GAP_WIDTH-1:0]   r_gap;
    logic [LEN_WIDTH-1:0]   r_beat_cnt;
    logic [CNT_WIDTH-1:0]   r_pkt_sent;
    logic [GAP_WIDTH-1:0]   r_gap_cnt;
    logic                   r_abort_pend;
    logic                   r_gen_enable;

    logic                   w_run;
    logic                   w_last;
    logic                   w_hs;
    logic                   w_pkt_end;
    logic                   w_start_acc;
    logic [CNT_WIDTH-1:0]   w_pkt_sent_inc;
    logic                   w_count_reached;

    assign w_run           = (r_state == ST_RUN);
    assign w_last          = w_run && (r_beat_cnt == r_len_m1);
    assign w_hs            = w_run && s_axis_tvalid && m_axis_tready;
    assign w_pkt_end       = w_hs && w_last;
    assign w_start_acc     = (r_state == ST_IDLE) && start;
    assign w_pkt_sent_inc  = r_pkt_sent + c_cnt_one;
    assign w_count_reached = (r_count != '0) && (w_pkt_sent_inc == r_count);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_pkt_end) begin
                    if (r_abort_pend || abort || w_count_reached) w_state_nxt = ST_DONE;
                    else if (r_gap != '0)                         w_state_nxt = ST_GAP;
                    else                                          w_state_nxt = ST_RUN;
                end
            end
            ST_GAP: begin
                if (abort)                      w_state_nxt = ST_DONE;
                else if (r_gap_cnt == c_gap_one) w_state_nxt = ST_RUN;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) r_state <= ST_IDLE;
        else                 r_state <= w_state_nxt;
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            r_len_m1     <= '0;
            r_count      <= '0;
            r_gap        <= '0;
            r_beat_cnt   <= '0;
            r_pkt_sent   <= '0;
            r_gap_cnt    <= '0;
            r_abort_pend <= 1'b0;
            r_gen_enable <= 1'b0;
        end else begin
            r_gen_enable <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_GAP);
            if (w_start_acc) begin
                // A zero length is stored as a one-beat packet
                r_len_m1     <= (cfg_pkt_len == '0) ? '0 : (cfg_pkt_len - c_len_one);
                r_count      <= cfg_pkt_count;
                r_gap        <= cfg_gap;
                r_beat_cnt   <= '0;
                r_pkt_sent   <= '0;
                r_abort_pend <= 1'b0;
            end
            if (w_hs) r_beat_cnt <= w_last ? '0 : (r_beat_cnt + c_len_one);
            if (w_pkt_end) r_pkt_sent <= w_pkt_sent_inc;
            if (w_run && abort) r_abort_pend <= 1'b1;
            if (w_pkt_end && (w_state_nxt == ST_GAP)) r_gap_cnt <= r_gap;
            else if (r_state == ST_GAP)               r_gap_cnt <= r_gap_cnt - c_gap_one;
        end
    end

    // Stream path is combinational so reset removes valid without waiting for a clock
    assign m_axis_tvalid = w_run && s_axis_tvalid;
    assign s_axis_tready = w_run && m_axis_tready;
    assign m_axis_tdata  = w_run ? s_axis_tdata : '0;
    assign m_axis_tlast  = w_last;
    assign busy          = (r_state != ST_IDLE);
    assign done          = (r_state == ST_DONE);
    assign pkt_sent      = r_pkt_sent;
    assign gen_enable    = r_gen_enable;

endmodule
`default_nettype wire

// File: tb/tb_axis_testpattern_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axis_testpattern_sequencer
// Description : Scoreboard bench for the packet-framing sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_testpattern_sequencer;

    localparam int TW = 32;
    localparam int LW = 16;
    localparam int CW = 16;
    localparam int GW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [LW-1:0] cfg_len = '0;
    logic [CW-1:0] cfg_count = '0;
    logic [GW-1:0] cfg_gap = '0;
    logic          gen_enable;
    logic [TW-1:0] gdata = '0;
    logic          s_tvalid = 1'b1;
    logic          s_tready;
    logic [TW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic          busy;
    logic          done;
    logic [CW-1:0] pkt_sent;

    axis_testpattern_sequencer #(
        .TDATA_WIDTH(TW), .LEN_WIDTH(LW), .CNT_WIDTH(CW), .GAP_WIDTH(GW)
    ) dut (
        .m_axis_aclk   (clk),
        .m_axis_aresetn(rstn),
        .start         (start),
        .abort         (abort),
        .cfg_pkt_len   (cfg_len),
        .cfg_pkt_count (cfg_count),
        .cfg_gap       (cfg_gap),
        .gen_enable    (gen_enable),
        .s_axis_tdata  (gdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .busy          (busy),
        .done          (done),
        .pkt_sent      (pkt_sent)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] data;
        logic          last;
    } beat_t;

    beat_t sb[$];
    int    hs_cyc[$];
    int    hs_count = 0;
    int    cyc = 0;
    int    n_checks = 0;
    int    n_pass = 0;
    bit    toggle_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Free-running generator: advances one word per accepted beat
    initial forever begin
        logic hs;
        @(negedge clk);
        hs = s_tvalid && s_tready;
        @(posedge clk);
        #1;
        if (hs) gdata = gdata + 32'd1;
        m_tready = toggle_mode ? cyc[0] : 1'b1;
    end

    // Monitor: every presented beat is compared with the head of the scoreboard
    initial forever begin
        beat_t e;
        @(negedge clk);
        if (rstn && m_tvalid) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", 32'(m_tvalid), 32'd0);
            end else begin
                e = sb[0];
                check("beat_data", m_tdata, e.data);
                check("beat_last", 32'(m_tlast), 32'(e.last));
                if (m_tready) begin
                    void'(sb.pop_front());
                    hs_cyc.push_back(cyc);
                    hs_count++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input int len, input int count, input int gap, input logic [31:0] base);
        cfg_len   = LW'(len);
        cfg_count = CW'(count);
        cfg_gap   = GW'(gap);
        gdata     = base;
        sb.delete();
        hs_cyc.delete();
        hs_count  = 0;
    endtask

    task automatic push_run(input logic [31:0] base, input int len, input int npkt);
        int    eff;
        int    idx;
        beat_t b;
        eff = (len == 0) ? 1 : len;
        idx = 0;
        for (int p = 0; p < npkt; p++) begin
            for (int k = 0; k < eff; k++) begin
                b.data = base + 32'(idx);
                b.last = (k == eff - 1);
                sb.push_back(b);
                idx++;
            end
        end
    endtask

    task automatic pulse_start(output int s);
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int d);
        d = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                d = cyc;
                break;
            end
        end
        if (d < 0) check("done_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic wait_hs(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (hs_count >= target) break;
            tick();
        end
        if (i == budget) check("beat_timeout", 32'(hs_count), 32'(target));
    endtask

    int s, d;

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gen_enable", 32'(gen_enable), 32'd0);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tready", 32'(s_tready), 32'd0);
        rstn = 1'b1;
        tick();
        check("idle_done", 32'(done), 32'd0);
        check("idle_pkt_sent", 32'(pkt_sent), 32'd0);

        // Basic run: len 4, count 3, gap 2
        setup(4, 3, 2, 32'h1000);
        push_run(32'h1000, 4, 3);
        check("basic_busy_pre", 32'(busy), 32'd0);
        pulse_start(s);
        check("basic_busy_rise", 32'(busy), 32'd1);
        check("basic_gen_en_rise", 32'(gen_enable), 32'd1);
        wait_done(100, d);
        check("basic_done_cycle", 32'(d), 32'(s + 17));
        check("basic_beats", 32'(hs_cyc.size()), 32'd12);
        if (hs_cyc.size() == 12) begin
            check("basic_first_beat", 32'(hs_cyc[0]), 32'(s + 1));
            check("basic_pkt2_start", 32'(hs_cyc[4]), 32'(s + 7));
            check("basic_pkt3_start", 32'(hs_cyc[8]), 32'(s + 13));
            check("basic_last_beat", 32'(hs_cyc[11]), 32'(s + 16));
        end
        check("basic_busy_fall", 32'(busy), 32'd0);
        check("basic_done_pulse", 32'(done), 32'd0);
        check("basic_pkt_sent", 32'(pkt_sent), 32'd3);
        check("basic_sb_empty", 32'(sb.size()), 32'd0);

        // Backpressure: len 5, count 2, gap 0, ready toggling
        setup(5, 2, 0, 32'h2000);
        push_run(32'h2000, 5, 2);
        toggle_mode = 1'b1;
        pulse_start(s);
        wait_done(200, d);
        toggle_mode = 1'b0;
        check("bp_pkt_sent", 32'(pkt_sent), 32'd2);
        check("bp_beats", 32'(hs_count), 32'd10);
        check("bp_sb_empty", 32'(sb.size()), 32'd0);
        tick();

        // Abort on beat 3 of packet 2 in continuous mode
        setup(8, 0, 0, 32'h3000);
        push_run(32'h3000, 8, 4);
        pulse_start(s);
        wait_hs(10, 200);
        pulse_abort();
        wait_done(200, d);
        check("abort_pkt_sent", 32'(pkt_sent), 32'd2);
        check("abort_beats", 32'(hs_count), 32'd16);
        sb.delete();
        repeat (5) tick();
        check("abort_idle", 32'(busy), 32'd0);

        // len 0 behaves as 1: every beat carries tlast
        setup(0, 3, 1, 32'h4000);
        push_run(32'h4000, 0, 3);
        pulse_start(s);
        wait_done(100, d);
        check("len0_done_cycle", 32'(d), 32'(s + 6));
        check("len0_pkt_sent", 32'(pkt_sent), 32'd3);
        check("len0_sb_empty", 32'(sb.size()), 32'd0);

        // Continuous run beyond 300 beats; a start while busy must not reconfigure
        setup(7, 0, 0, 32'h5000);
        push_run(32'h5000, 7, 50);
        pulse_start(s);
        wait_hs(100, 300);
        cfg_len   = LW'(3);
        cfg_count = CW'(1);
        pulse_start(s);
        wait_hs(310, 600);
        pulse_abort();
        wait_done(100, d);
        check("cont_pkt_sent", 32'(pkt_sent), 32'd45);
        check("cont_sb_left", 32'(sb.size()), 32'd35);
        sb.delete();
        tick();

        // Reset asserted while in GAP
        setup(4, 2, 5, 32'h6000);
        push_run(32'h6000, 4, 2);
        pulse_start(s);
        wait_hs(4, 50);
        tick();
        check("gap_busy", 32'(busy), 32'd1);
        check("gap_tvalid", 32'(m_tvalid), 32'd0);
        #2;
        rstn = 1'b0;
        #1;
        check("rstgap_busy", 32'(busy), 32'd0);
        check("rstgap_gen_enable", 32'(gen_enable), 32'd0);
        check("rstgap_pkt_sent", 32'(pkt_sent), 32'd0);
        check("rstgap_tvalid", 32'(m_tvalid), 32'd0);
        check("rstgap_tlast", 32'(m_tlast), 32'd0);
        sb.delete();
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        setup(2, 1, 0, 32'h7000);
        push_run(32'h7000, 2, 1);
        pulse_start(s);
        wait_done(50, d);
        check("post_rst_done_cycle", 32'(d), 32'(s + 3));
        check("post_rst_pkt_sent", 32'(pkt_sent), 32'd1);
        check("post_rst_sb_empty", 32'(sb.size()), 32'd0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
